alu_mul_sequencer: RTL and testbench

//   Multi-cycle shift-add sequencer computing RV32 MUL (low 32 bits of a*b) by driving the shared ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings understood by the shared ALU and
// the state encoding of the multiply sequencer that borrows it.
// No ports; imported by the sequencer and by anything that drives the ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add sequencer computing the low word of a*b through the shared ALU.
// Latency: DONE arrives 1 + (ADD+SHIFT steps) cycles after an accepted start when gnt stays high.
// Backpressure: each step waits in place (registers and alu_* stable) until alu_gnt is seen with alu_req.
// Ports: clk/reset_n (async active-low); start/flush control; op_a/op_b operands;
//        busy/done/product status; alu_req/alu_gnt handshake; alu_a/alu_b/alu_control to the ALU,
//        alu_result back from it.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  localparam int  CW = $clog2(XLEN);
  localparam bit  EE = (EARLY_EXIT != 0);
  localparam logic [CW-1:0] LAST_BIT = CW'(XLEN - 1);

  mulseq_state_t   state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] product_q, product_d;
  logic [XLEN-1:0] mplier_nxt;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    product_d   = product_q;
    busy        = 1'b0;
    done        = 1'b0;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    mplier_nxt  = mplier_q >> 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          count_d  = '0;
          if (EE && (op_b == '0)) begin
            // acc is being cleared on this same edge, so load the zero
            // product directly rather than the stale acc.
            state_d   = DONE;
            product_d = '0;
          end else if (op_b[0]) begin
            state_d = ADD;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      ADD: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_a   = acc_q;
        alu_b   = mcand_q;
        if (alu_gnt) begin
          acc_d   = alu_result;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy        = 1'b1;
        alu_req     = 1'b1;
        alu_a       = mcand_q;
        alu_b       = XLEN'(1);
        alu_control = ALU_SLL;
        if (alu_gnt) begin
          mcand_d  = alu_result;
          mplier_d = mplier_nxt;
          count_d  = count_q + 1'b1;
          // The last bit step exits before count could wrap.
          if ((count_q == LAST_BIT) || (EE && (mplier_nxt == '0))) begin
            state_d   = DONE;
            product_d = acc_q;
          end else if (mplier_nxt[0]) begin
            state_d = ADD;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abort wins over grant and start: no product update, no done pulse.
    if (flush) begin
      state_d   = IDLE;
      product_d = product_q;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, alu_gnt, start0, start1, sel;
  logic [31:0] op_a, op_b;

  logic        busy0, done0, alu_req0, busy1, done1, alu_req1;
  logic [31:0] product0, alu_a0, alu_b0, alu_result0;
  logic [31:0] product1, alu_a1, alu_b1, alu_result1;
  logic [2:0]  alu_control0, alu_control1;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the shared ALU.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] ctl);
    case (ctl)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_LUI: return b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result0 = alu_f(alu_a0, alu_b0, alu_control0);
  assign alu_result1 = alu_f(alu_a1, alu_b1, alu_control1);

  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0), .product(product0),
    .alu_req(alu_req0), .alu_gnt(alu_gnt), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_control(alu_control0), .alu_result(alu_result0));

  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1), .product(product1),
    .alu_req(alu_req1), .alu_gnt(alu_gnt), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_control(alu_control1), .alu_result(alu_result1));

  // Observation mux: sel picks which instance a run watches.
  logic        busy_s, done_s, alu_req_s;
  logic [31:0] product_s, alu_a_s, alu_b_s;
  logic [2:0]  alu_control_s;
  assign busy_s        = sel ? busy1        : busy0;
  assign done_s        = sel ? done1        : done0;
  assign alu_req_s     = sel ? alu_req1     : alu_req0;
  assign product_s     = sel ? product1     : product0;
  assign alu_a_s       = sel ? alu_a1       : alu_a0;
  assign alu_b_s       = sel ? alu_b1       : alu_b0;
  assign alu_control_s = sel ? alu_control1 : alu_control0;

  typedef struct packed {
    logic [31:0] prod;
    logic [31:0] steps;
    logic [31:0] lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Number of ADD+SHIFT steps the algorithm takes for multiplier b.
  function automatic int model_steps(input logic [31:0] b, input bit ee);
    logic [31:0] mp;
    int k;
    mp = b;
    k  = 0;
    if (ee && mp == 32'd0) return 0;
    for (int i = 0; i < 32; i++) begin
      if (mp[0]) k++;
      k++;
      mp = mp >> 1;
      if (ee && mp == 32'd0) break;
    end
    return k;
  endfunction

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // mode 0: gnt always high; 1: gnt toggles 1,0,1,...; 2: gnt high plus stray starts.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input int mode);
    exp_t        e;
    int          cyc, steps, reqs;
    bit          got;
    logic [31:0] pa, pb;
    logic [2:0]  pc;
    logic        pg, preq;
    @(negedge clk);
    sel = s; op_a = a; op_b = b; alu_gnt = 1'b1;
    set_start(s, 1'b1);
    e.prod  = a * b;
    e.steps = 32'(model_steps(b, !s));
    e.lat   = 32'(1 + model_steps(b, !s));
    sb.push_back(e);
    @(negedge clk);
    set_start(s, 1'b0);
    op_a = 32'hDEAD_BEEF; op_b = 32'hFFFF_FFFF;
    cyc = 1; got = 1'b0; steps = 0; reqs = 0;
    pg = 1'b1; preq = 1'b0; pa = '0; pb = '0; pc = '0;
    while (!got && cyc <= 200) begin
      if (done_s) begin
        got = 1'b1;
      end else begin
        alu_gnt = (mode == 1) ? cyc[0] : 1'b1;
        if (mode == 1 && !pg && preq) begin
          check({tag, "_hold_a"}, alu_a_s, pa);
          check({tag, "_hold_b"}, alu_b_s, pb);
          check({tag, "_hold_ctl"}, 32'(alu_control_s), 32'(pc));
        end
        pa = alu_a_s; pb = alu_b_s; pc = alu_control_s; pg = alu_gnt; preq = alu_req_s;
        if (alu_req_s) reqs++;
        if (alu_req_s && alu_gnt) steps++;
        if (mode == 2 && cyc == 2) begin
          op_a = 32'd99; op_b = 32'd0; set_start(s, 1'b1);
        end else begin
          set_start(s, 1'b0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_product"}, product_s, e.prod);
      check({tag, "_steps"}, 32'(steps), e.steps);
      if (mode != 1) begin
        check({tag, "_latency"}, 32'(cyc), e.lat);
        check({tag, "_req_cycles"}, 32'(reqs), e.steps);
      end
    end
    // A start during the DONE cycle must be ignored.
    if (mode == 2) begin
      op_a = 32'd5; op_b = 32'd5; set_start(s, 1'b1);
    end
    @(negedge clk);
    set_start(s, 1'b0);
    check({tag, "_done_one_pulse"}, 32'(done_s), 32'd0);
    check({tag, "_idle_after"}, 32'(busy_s), 32'd0);
    check({tag, "_product_held"}, product_s, e.prod);
  endtask

  initial begin
    int dones;
    reset_n = 1'b0; flush = 1'b0; alu_gnt = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sel = 1'b0; op_a = '0; op_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_req", 32'(alu_req0), 32'd0);
    check("rst_product", product0, 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);

    run_mul("mul7x6", 32'd7, 32'd6, 1'b0, 2);
    run_mul("mul_b0", 32'h1234_5678, 32'd0, 1'b0, 0);
    run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_mul("mul3x5_tog", 32'd3, 32'd5, 1'b0, 1);

    // Flush during the third SHIFT of 0xFFFF*0xFFFF.
    @(negedge clk);
    sel = 1'b0; alu_gnt = 1'b1; op_a = 32'hFFFF; op_b = 32'hFFFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_in_shift_busy", 32'(busy0), 32'd1);
    check("flush_in_shift_ctl", 32'(alu_control0), 32'(ALU_SLL));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy0), 32'd0);
    check("flush_req", 32'(alu_req0), 32'd0);
    check("flush_done", 32'(done0), 32'd0);
    check("flush_product", product0, 32'd15);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) dones++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(dones), 32'd0);
    run_mul("mul2x2", 32'd2, 32'd2, 1'b0, 0);

    // Asynchronous reset in the middle of an ADD.
    @(negedge clk);
    sel = 1'b0; alu_gnt = 1'b1; op_a = 32'd3; op_b = 32'd5; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; alu_gnt = 1'b0;
    check("pre_rst_req", 32'(alu_req0), 32'd1);
    check("pre_rst_ctl", 32'(alu_control0), 32'(ALU_ADD));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_req", 32'(alu_req0), 32'd0);
    check("async_rst_product", product0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; alu_gnt = 1'b1;

    run_mul("mul1x1_noee", 32'd1, 32'd1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
